// File: rtl/fuzz_vector_sequencer_if.sv
// Signal bundle between the fuzz vector sequencer (slave) and its harness (master).
// The golden-compare ports exist only when FUZZ_SEQ_GOLDEN_CHECK_EN is defined.
interface fuzz_vector_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic [31:0]      seed_i;
  logic [CNT_W-1:0] num_vec_i;
  logic [31:0]      dut_in_0_o;
  logic [31:0]      dut_in_1_o;
  logic [31:0]      dut_in_2_o;
  logic [31:0]      dut_out_0_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] vec_idx_o;
  logic [31:0]      signature_o;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
  logic [31:0]      golden_i;
  logic             mismatch_o;

  modport slave (
    input  start_i, abort_i, seed_i, num_vec_i, dut_out_0_i, golden_i,
    output dut_in_0_o, dut_in_1_o, dut_in_2_o, busy_o, done_o, vec_idx_o,
           signature_o, mismatch_o
  );
  modport master (
    output start_i, abort_i, seed_i, num_vec_i, dut_out_0_i, golden_i,
    input  dut_in_0_o, dut_in_1_o, dut_in_2_o, busy_o, done_o, vec_idx_o,
           signature_o, mismatch_o
  );
`else
  modport slave (
    input  start_i, abort_i, seed_i, num_vec_i, dut_out_0_i,
    output dut_in_0_o, dut_in_1_o, dut_in_2_o, busy_o, done_o, vec_idx_o,
           signature_o
  );
  modport master (
    output start_i, abort_i, seed_i, num_vec_i, dut_out_0_i,
    input  dut_in_0_o, dut_in_1_o, dut_in_2_o, busy_o, done_o, vec_idx_o,
           signature_o
  );
`endif
endinterface

// File: rtl/fuzz_vector_sequencer.sv
// Drives a combinational fuzz DUT from three Galois LFSRs and folds its output into a MISR.
// Optional golden-signature compare is enabled with FUZZ_SEQ_GOLDEN_CHECK_EN.
module fuzz_vector_sequencer #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16,
  parameter logic [31:0] LFSR_POLY  = 32'h80200003,
  parameter logic [31:0] MISR_POLY  = 32'h04C11DB7,
  parameter logic [31:0] MISR_INIT  = 32'hFFFFFFFF
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  fuzz_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  localparam logic [31:0] SEED1_XOR   = 32'h9E3779B9;
  localparam logic [31:0] SEED2_XOR   = 32'h7F4A7C15;
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYC);
  // With no settle time every vector goes straight to its capture cycle.
  localparam state_t      RUN_ST      = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
    return ({m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0)) ^ d;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      lfsr0_q, lfsr0_d;
  logic [31:0]      lfsr1_q, lfsr1_d;
  logic [31:0]      lfsr2_q, lfsr2_d;
  logic [31:0]      misr_q, misr_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
  logic             mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d = state_q;
    lfsr0_d = lfsr0_q;
    lfsr1_d = lfsr1_q;
    lfsr2_d = lfsr2_q;
    misr_d  = misr_q;
    num_d   = num_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          lfsr0_d = seed_fix(bus.seed_i);
          lfsr1_d = seed_fix(bus.seed_i ^ SEED1_XOR);
          lfsr2_d = seed_fix(bus.seed_i ^ SEED2_XOR);
          num_d   = bus.num_vec_i;
          misr_d  = MISR_INIT;
          idx_d   = '0;
          cnt_d   = SETTLE_INIT;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
          mismatch_d = 1'b0;
`endif
          state_d = (bus.num_vec_i == '0) ? DONE : RUN_ST;
        end
      end
      SETTLE: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Abort wins over the capture: the MISR and LFSRs keep their values.
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          misr_d = misr_step(misr_q, bus.dut_out_0_i);
          if (idx_q == num_q - CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            lfsr0_d = lfsr_step(lfsr0_q);
            lfsr1_d = lfsr_step(lfsr1_q);
            lfsr2_d = lfsr_step(lfsr2_q);
            idx_d   = idx_q + CNT_W'(1);
            cnt_d   = SETTLE_INIT;
            state_d = RUN_ST;
          end
        end
      end
      DONE: begin
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
        mismatch_d = (misr_q != bus.golden_i);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr0_q <= 32'h1;
      lfsr1_q <= 32'h1;
      lfsr2_q <= 32'h1;
      misr_q  <= MISR_INIT;
      num_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr0_q <= lfsr0_d;
      lfsr1_q <= lfsr1_d;
      lfsr2_q <= lfsr2_d;
      misr_q  <= misr_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign bus.dut_in_0_o  = lfsr0_q;
  assign bus.dut_in_1_o  = lfsr1_q;
  assign bus.dut_in_2_o  = lfsr2_q;
  assign bus.busy_o      = (state_q == SETTLE) || (state_q == CAPTURE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.vec_idx_o   = idx_q;
  assign bus.signature_o = misr_q;
`ifdef FUZZ_SEQ_GOLDEN_CHECK_EN
  assign bus.mismatch_o  = mismatch_q;
`endif

endmodule
